// File: rtl/shift_sequencer_if.sv
// Start/busy/done handshake between pipeline control and the iterative shift sequencer.
// Operand, amount and op are presented with start; the result holds on Out until the next completion.
interface shift_sequencer_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
);
   logic             start;
   logic [WIDTH-1:0] In;
   logic [CNT_W-1:0] Cnt;
   logic [1:0]       Op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Out;

   modport master (output start, In, Cnt, Op, input busy, done, Out);
   modport slave  (input start, In, Cnt, Op, output busy, done, Out);
endinterface

// File: rtl/shift_sequencer.sv
// Iterative 1-bit-per-cycle rotate/shift unit; SHIFT_SEQ_DOUBLE_STEP_EN enables two steps per cycle.
// Latency Cnt+1 cycles (ceil(Cnt/2)+1 with double step); start is ignored while busy, no queueing.
module shift_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   shift_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opnd_q,  opnd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [1:0]       op_q,    op_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v, input logic [1:0] op);
      case (op)
         2'b00:   step1 = {v[WIDTH-2:0], v[WIDTH-1]};
         2'b01:   step1 = {v[WIDTH-2:0], 1'b0};
         2'b10:   step1 = {v[0], v[WIDTH-1:1]};
         default: step1 = {1'b0, v[WIDTH-1:1]};
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      count_d = count_q;
      op_d    = op_q;
      out_d   = out_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               opnd_d  = bus.In;
               count_d = bus.Cnt;
               op_d    = bus.Op;
               busy_d  = 1'b1;
               state_d = (bus.Cnt != '0) ? SHIFT : FINISH;
            end
         end
         SHIFT: begin
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
            if (count_q >= CNT_W'(2)) begin
               opnd_d  = step1(step1(opnd_q, op_q), op_q);
               count_d = count_q - CNT_W'(2);
            end else begin
               opnd_d  = step1(opnd_q, op_q);
               count_d = count_q - CNT_W'(1);
            end
            if (count_q <= CNT_W'(2)) begin
               state_d = FINISH;
            end
`else
            opnd_d  = step1(opnd_q, op_q);
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = FINISH;
            end
`endif
         end
         FINISH: begin
            // busy drops with done so control can issue the next start in the done cycle
            out_d   = opnd_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opnd_q  <= '0;
         count_q <= '0;
         op_q    <= '0;
         out_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         count_q <= count_d;
         op_q    <= op_d;
         out_q   <= out_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.Out  = out_q;

endmodule
